// File: rtl/ifetch_pkg.sv
// Shared encodings for the instruction-fetch sequencing controller:
// next-PC select codes, FSM states and the redirect priority ranking.
package ifetch_pkg;

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_IFBR = 3'd1;
  localparam logic [2:0] SEL_J    = 3'd2;
  localparam logic [2:0] SEL_JR   = 3'd3;
  localparam logic [2:0] SEL_NBR  = 3'd4;
  localparam logic [2:0] SEL_INT  = 3'd5;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Rank used when deciding whether a new redirect displaces a pending one.
  function automatic logic [2:0] sel_prio(input logic [2:0] sel);
    logic [2:0] rank;
    case (sel)
      SEL_INT:  rank = 3'd5;
      SEL_NBR:  rank = 3'd4;
      SEL_JR:   rank = 3'd3;
      SEL_J:    rank = 3'd2;
      SEL_IFBR: rank = 3'd1;
      default:  rank = 3'd0;
    endcase
    return rank;
  endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Combinational priority encoder from the redirect request bits to a
// next-PC select code; valid=0 means plain sequential fetch.
module redirect_prio_enc
  import ifetch_pkg::*;
(
  input  logic       cp0_req,
  input  logic       n_branch,
  input  logic       jr,
  input  logic       j,
  input  logic       if_branch,
  output logic       valid,
  output logic [2:0] sel
);

  always_comb begin
    valid = 1'b1;
    sel   = SEL_SEQ;
    if (cp0_req)        sel = SEL_INT;
    else if (n_branch)  sel = SEL_NBR;
    else if (jr)        sel = SEL_JR;
    else if (j)         sel = SEL_J;
    else if (if_branch) sel = SEL_IFBR;
    else                valid = 1'b0;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencing controller: next-PC arbitration, ROM wait
// states, load-use stalls and pipeline flush/hold generation.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int ROM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cp0_wen,
  input  logic       back_from_eret,
  input  logic       n_branch,
  input  logic       jr,
  input  logic       j,
  input  logic       if_branch,
  input  logic       load_use,
  output logic       pc_write,
  output logic [2:0] npc_sel,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       if_back_from_eret,
  output logic       busy
);

  localparam bit HAS_WAIT = (ROM_WAIT > 0);
  localparam logic [CNT_W-1:0] WAIT_INIT =
    HAS_WAIT ? CNT_W'(ROM_WAIT - 1) : {CNT_W{1'b0}};

  state_t           state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [2:0]       pend_sel_reg;
  logic             pend_v_reg;
  logic             back_eret_reg;

  logic             req_valid;
  logic [2:0]       req_sel;
  logic [2:0]       run_sel;
  logic             req_beats_pend;

  redirect_prio_enc u_prio (
    .cp0_req   (cp0_wen),
    .n_branch  (n_branch),
    .jr        (jr),
    .j         (j),
    .if_branch (if_branch),
    .valid     (req_valid),
    .sel       (req_sel)
  );

  assign req_beats_pend = sel_prio(req_sel) > sel_prio(pend_sel_reg);
  // A live request only displaces the pending entry if strictly higher ranked.
  assign run_sel = (pend_v_reg && !req_beats_pend) ? pend_sel_reg : req_sel;
  assign if_back_from_eret = back_eret_reg;

  always_comb begin
    pc_write   = 1'b0;
    npc_sel    = SEL_SEQ;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      busy = (state_reg == WAIT);
      if (cp0_wen) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        npc_sel    = SEL_INT;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (state_reg == RUN) begin
        if (load_use) begin
          idex_flush = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          npc_sel    = run_sel;
          ifid_flush = (run_sel == SEL_NBR) || (run_sel == SEL_JR) ||
                       (run_sel == SEL_J);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      pend_sel_reg  <= SEL_SEQ;
      pend_v_reg    <= 1'b0;
      back_eret_reg <= 1'b0;
    end else begin
      back_eret_reg <= back_from_eret;
      if (cp0_wen) begin
        pend_v_reg   <= 1'b0;
        pend_sel_reg <= SEL_SEQ;
        state_reg    <= HAS_WAIT ? WAIT : RUN;
        wait_cnt_reg <= WAIT_INIT;
      end else begin
        case (state_reg)
          RUN: begin
            // A stalled cycle leaves any pending redirect in place.
            if (!load_use) begin
              pend_v_reg   <= 1'b0;
              pend_sel_reg <= SEL_SEQ;
              if (HAS_WAIT) begin
                state_reg    <= WAIT;
                wait_cnt_reg <= WAIT_INIT;
              end
            end
          end
          WAIT: begin
            if (wait_cnt_reg == '0) begin
              state_reg <= RUN;
            end else begin
              wait_cnt_reg <= wait_cnt_reg - 1'b1;
            end
            if (!load_use && req_valid && (!pend_v_reg || req_beats_pend)) begin
              pend_v_reg   <= 1'b1;
              pend_sel_reg <= req_sel;
            end
          end
          default: state_reg <= RUN;
        endcase
      end
    end
  end

endmodule
